tb_uart_monitor_mc: RTL and testbench

Parametrised multi-channel UART capture monitor for the simulation environment. It is the successor to the single-channel UART message monitor.
- Samples N DUT TXD lines and decodes 8N1 frames.
- Buffers received bytes per channel in a FIFO.
- Raises a sticky done flag when a termination character arrives, which feeds the testbench finish logic.
- Written as synthesizable RTL, so the same block can sit on an FPGA debug build.

---
 rtl/tb_uart_pkg.sv | 20 ++
 rtl/tb_uart_rx_ch.sv | 239 +++++++++++++++++++++++
 rtl/tb_uart_monitor_mc.sv | 51 +++++
 tb/tb_tb_uart_monitor_mc.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_uart_pkg.sv
// Shared types and constants for the multi-channel UART capture monitor.
package tb_uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_e;

    // The divider must hold CLK_DIV-1; keep at least one bit for degenerate values.
    function automatic int div_width(input int clk_div);
        return (clk_div < 2) ? 1 : $clog2(clk_div);
    endfunction

endpackage

// File: rtl/tb_uart_rx_ch.sv
// One UART capture channel: input synchroniser, 8N1 receive FSM, byte FIFO and sticky flags.
// Defining TB_UART_PARITY_EN adds an even-parity bit between the data and stop bits.
module tb_uart_rx_ch
    import tb_uart_pkg::*;
#(
    parameter int                CLK_DIV    = 434,
    parameter int                FIFO_DEPTH = 16,
    parameter logic [BYTE_W-1:0] DONE_CHAR  = 8'h04
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    input  logic              rd_en,
    output logic [BYTE_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              fifo_empty,
    output logic              overflow,
    output logic              frame_err,
    output logic              parity_err,
    output logic              done
);

    localparam int DIV_W = div_width(CLK_DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_FULL = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic rxd_meta_q;
    logic rxd_s_q;
    logic rxd_prev_q;

    // Idle-high line: all stages reset to 1 so reset release never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
            rxd_prev_q <= rxd_s_q;
        end
    end

    rx_state_e         state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [2:0]        bit_q, bit_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              push_q, push_d;
    logic              frame_err_q, frame_err_d;
`ifdef TB_UART_PARITY_EN
    logic              par_bad_q, par_bad_d;
    logic              parity_err_q, parity_err_d;
`endif
    logic              tick;

    assign tick = (div_q == '0);

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        frame_err_d = frame_err_q;
`ifdef TB_UART_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = parity_err_q;
`endif
        if (state_q != IDLE && state_q != BREAK && !tick) begin
            div_d = div_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (rxd_prev_q && !rxd_s_q) begin
                    div_d   = DIV_HALF;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (rxd_s_q) begin
                        state_d = IDLE;
                    end else begin
                        div_d   = DIV_FULL;
                        bit_d   = 3'd0;
                        state_d = DATA;
`ifdef TB_UART_PARITY_EN
                        par_bad_d = 1'b0;
`endif
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {rxd_s_q, shift_q[BYTE_W-1:1]};
                    div_d   = DIV_FULL;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef TB_UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef TB_UART_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if ((^shift_q) != rxd_s_q) begin
                        par_bad_d    = 1'b1;
                        parity_err_d = 1'b1;
                    end
                    div_d   = DIV_FULL;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (rxd_s_q) begin
`ifdef TB_UART_PARITY_EN
                        push_d = !par_bad_q;
`else
                        push_d = 1'b1;
`endif
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxd_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef TB_UART_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    // shift_q stays stable long after the stop sample, so it doubles as the push data.
    logic [BYTE_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [BYTE_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              done_q, done_d;
    logic              pop;
    logic              push_ok;

    always_comb begin
        pop        = rd_en && (count_q != '0);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        push_ok    = push_q && ((count_q != CNT_FULL) || pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        rd_data_d  = pop ? mem[rd_ptr_q] : rd_data_q;
        rd_valid_d = pop;
        overflow_d = overflow_q | (push_q && !push_ok);
        done_d     = done_q | (push_q && (shift_q == DONE_CHAR));
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign fifo_empty = (count_q == '0);
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;
    assign done       = done_q;

endmodule

// File: rtl/tb_uart_monitor_mc.sv
// Multi-channel UART capture monitor: CH_NUM independent receivers, done is the OR of all channels.
// Optional even-parity framing is enabled with the TB_UART_PARITY_EN macro.
module tb_uart_monitor_mc
    import tb_uart_pkg::*;
#(
    parameter int                CH_NUM     = 2,
    parameter int                CLK_DIV    = 434,
    parameter int                FIFO_DEPTH = 16,
    parameter logic [BYTE_W-1:0] DONE_CHAR  = 8'h04
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH_NUM-1:0]        rxd,
    input  logic [CH_NUM-1:0]        rd_en,
    output logic [CH_NUM*BYTE_W-1:0] rd_data,
    output logic [CH_NUM-1:0]        rd_valid,
    output logic [CH_NUM-1:0]        fifo_empty,
    output logic [CH_NUM-1:0]        overflow,
    output logic [CH_NUM-1:0]        frame_err,
    output logic [CH_NUM-1:0]        parity_err,
    output logic                     done
);

    logic [CH_NUM-1:0] done_ch;

    genvar gi;
    generate
        for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
            tb_uart_rx_ch #(
                .CLK_DIV    (CLK_DIV),
                .FIFO_DEPTH (FIFO_DEPTH),
                .DONE_CHAR  (DONE_CHAR)
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .rxd        (rxd[gi]),
                .rd_en      (rd_en[gi]),
                .rd_data    (rd_data[gi*BYTE_W +: BYTE_W]),
                .rd_valid   (rd_valid[gi]),
                .fifo_empty (fifo_empty[gi]),
                .overflow   (overflow[gi]),
                .frame_err  (frame_err[gi]),
                .parity_err (parity_err[gi]),
                .done       (done_ch[gi])
            );
        end
    endgenerate

    assign done = |done_ch;

endmodule

// File: tb/tb_tb_uart_monitor_mc.sv
// Self-checking bench for tb_uart_monitor_mc: vector table, corner sequences and a queue-based reference model.
module tb_tb_uart_monitor_mc;

    localparam int         CH    = 2;
    localparam int         DIV   = 16;
    localparam int         DEPTH = 16;
    localparam logic [7:0] EOT   = 8'h04;
`ifdef TB_UART_PARITY_EN
    localparam int         STOP_OFS = 10 * DIV;
`else
    localparam int         STOP_OFS = 9 * DIV;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   rxd;
    logic [CH-1:0]   rd_en;
    logic [CH*8-1:0] rd_data;
    logic [CH-1:0]   rd_valid;
    logic [CH-1:0]   fifo_empty;
    logic [CH-1:0]   overflow;
    logic [CH-1:0]   frame_err;
    logic [CH-1:0]   parity_err;
    logic            done;

    always #5 clk = ~clk;

    tb_uart_monitor_mc #(
        .CH_NUM     (CH),
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (DEPTH),
        .DONE_CHAR  (EOT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .fifo_empty (fifo_empty),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .done        (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per-channel byte queues plus sticky flags.
    logic [7:0]    mq [CH][$];
    logic [CH-1:0] m_ovf;
    logic [CH-1:0] m_ferr;
    logic [CH-1:0] m_perr;
    logic          m_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic logic [CH-1:0] m_empty();
        logic [CH-1:0] e;
        for (int c = 0; c < CH; c++) e[c] = (mq[c].size() == 0);
        return e;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) mq[c].delete();
        m_ovf  = '0;
        m_ferr = '0;
        m_perr = '0;
        m_done = 1'b0;
    endtask

    task automatic model_frame(input int ch, input logic [7:0] data, input logic stop_ok, input logic par_ok);
        if (!par_ok) m_perr[ch] = 1'b1;
        if (!stop_ok) m_ferr[ch] = 1'b1;
        if (stop_ok && par_ok) begin
            if (data == EOT) m_done = 1'b1;
            if (mq[ch].size() < DEPTH) mq[ch].push_back(data);
            else m_ovf[ch] = 1'b1;
        end
    endtask

    // Drives one frame on rxd[ch]; each bit lasts DIV clocks, followed by DIV clocks of idle.
    task automatic send_frame(input int ch, input logic [7:0] data, input logic stop_bit, input logic par_flip);
        logic [10:0] bits;
        int          n;
`ifdef TB_UART_PARITY_EN
        bits = {stop_bit, (^data) ^ par_flip, data, 1'b0};
        n    = 11;
`else
        bits = {1'b0, stop_bit, data, 1'b0};
        n    = 10;
`endif
        $display("tx   ch%0d data=%02h stop=%0b pflip=%0b", ch, data, stop_bit, par_flip);
        for (int i = 0; i < n; i++) begin
            rxd[ch] = bits[i];
            repeat (DIV) @(posedge clk);
            #1;
        end
        rxd[ch] = 1'b1;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int ch, input logic [7:0] data, input logic stop_ok, input logic par_flip);
        logic par_ok;
`ifdef TB_UART_PARITY_EN
        par_ok = !par_flip;
`else
        par_ok = 1'b1;
`endif
        send_frame(ch, data, stop_ok, par_flip);
        model_frame(ch, data, stop_ok, par_ok);
    endtask

    task automatic pop_exp(input int ch, input logic exp_valid, input logic [7:0] exp_data, input string name);
        @(posedge clk);
        #1;
        rd_en[ch] = 1'b1;
        @(posedge clk);
        #1;
        rd_en[ch] = 1'b0;
        check({name, " rd_valid"}, 32'(rd_valid[ch]), 32'(exp_valid));
        if (exp_valid) check({name, " rd_data"}, 32'(rd_data[ch*8 +: 8]), 32'(exp_data));
        @(posedge clk);
        #1;
        check({name, " rd_valid pulse"}, 32'(rd_valid[ch]), 32'(0));
    endtask

    task automatic pop_model(input int ch, input string name);
        logic [7:0] d;
        if (mq[ch].size() > 0) begin
            d = mq[ch].pop_front();
            pop_exp(ch, 1'b1, d, name);
        end else begin
            pop_exp(ch, 1'b0, 8'h00, name);
        end
    endtask

    task automatic check_flags(input string name);
        check({name, " overflow"},   32'(overflow),   32'(m_ovf));
        check({name, " frame_err"},  32'(frame_err),  32'(m_ferr));
        check({name, " parity_err"}, 32'(parity_err), 32'(m_perr));
        check({name, " done"},       32'(done),       32'(m_done));
        check({name, " fifo_empty"}, 32'(fifo_empty), 32'(m_empty()));
    endtask

    typedef struct {
        int         ch;
        logic [7:0] data;
        logic       stop_ok;
        logic [1:0] exp_ferr;
        logic       exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int         n_push_seen;
        int         ch;
        logic [7:0] tmp;

        vecs[0] = '{0, 8'h41, 1'b1, 2'b00, 1'b1, 8'h41};
        vecs[1] = '{1, 8'h55, 1'b0, 2'b10, 1'b0, 8'h00};
        vecs[2] = '{1, 8'hA5, 1'b1, 2'b10, 1'b1, 8'hA5};
        vecs[3] = '{0, 8'h00, 1'b1, 2'b10, 1'b1, 8'h00};
        vecs[4] = '{0, 8'hFF, 1'b1, 2'b10, 1'b1, 8'hFF};
        vecs[5] = '{1, 8'h80, 1'b1, 2'b10, 1'b1, 8'h80};
        vecs[6] = '{0, 8'h7E, 1'b0, 2'b11, 1'b0, 8'h00};
        vecs[7] = '{0, 8'hC3, 1'b1, 2'b11, 1'b1, 8'hC3};

        model_reset();
        rst   = 1'b1;
        rxd   = '1;
        rd_en = '0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset rd_data", 32'(rd_data), 32'(0));
        check("reset rd_valid", 32'(rd_valid), 32'(0));
        check("reset fifo_empty", 32'(fifo_empty), 32'(2'b11));
        check_flags("reset");
        n_push_seen = 0;
        repeat (10 * DIV) begin
            @(posedge clk);
            #1;
            if (fifo_empty !== 2'b11) n_push_seen++;
        end
        check("idle cycles with a push", 32'(n_push_seen), 32'(0));

        // Short low pulse on channel 1 must be rejected at the start-bit sample.
        rxd[1] = 1'b0;
        repeat (DIV / 4) @(posedge clk);
        #1;
        rxd[1] = 1'b1;
        repeat (3 * DIV) @(posedge clk);
        #1;
        check("glitch fifo_empty", 32'(fifo_empty), 32'(2'b11));
        check("glitch frame_err", 32'(frame_err), 32'(0));

        for (int i = 0; i < 8; i++) begin
            xfer(vecs[i].ch, vecs[i].data, vecs[i].stop_ok, 1'b0);
            check($sformatf("vec%0d frame_err", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d fifo_empty", i), 32'(fifo_empty[vecs[i].ch]), 32'(!vecs[i].exp_valid));
            check($sformatf("vec%0d other ch empty", i), 32'(fifo_empty[1 - vecs[i].ch]), 32'(1));
            pop_exp(vecs[i].ch, vecs[i].exp_valid, vecs[i].exp_data, $sformatf("vec%0d", i));
            if (mq[vecs[i].ch].size() > 0) tmp = mq[vecs[i].ch].pop_front();
            check($sformatf("vec%0d drained", i), 32'(fifo_empty), 32'(2'b11));
        end

        // EOT on channel 1 while channel 0 receives concurrently; done must rise right after the stop sample.
        check("done before EOT", 32'(done), 32'(0));
        @(posedge clk);
        #1;
        fork
            xfer(1, EOT, 1'b1, 1'b0);
            xfer(0, 8'h33, 1'b1, 1'b0);
            begin
                repeat (STOP_OFS + DIV / 2 - 1) @(posedge clk);
                #1;
                check("done before stop sample", 32'(done), 32'(0));
                repeat (7) @(posedge clk);
                #1;
                check("done after stop sample", 32'(done), 32'(1));
            end
        join
        check_flags("after EOT");
        pop_model(1, "EOT pop ch1");
        pop_model(0, "concurrent pop ch0");
        check("done sticky", 32'(done), 32'(1));

        for (int i = 0; i <= DEPTH; i++) xfer(0, 8'(i), 1'b1, 1'b0);
        check("overflow ch0", 32'(overflow[0]), 32'(1));
        check_flags("after overflow");
        for (int i = 0; i < DEPTH; i++) pop_model(0, $sformatf("ovf pop%0d", i));
        pop_model(0, "pop when empty");
        for (int i = 0; i < DEPTH; i++) xfer(0, 8'(8'h60 + i), 1'b1, 1'b0);
        check("wrap full, no new overflow on ch1", 32'(overflow[1]), 32'(0));
        for (int i = 0; i < DEPTH; i++) pop_model(0, $sformatf("wrap pop%0d", i));

        for (int i = 0; i < 30; i++) begin
            ch = $urandom_range(0, 1);
            xfer(ch, 8'($urandom), ($urandom_range(0, 7) != 0), (ch == 1) && ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 1) == 1) pop_model($urandom_range(0, 1), $sformatf("rand pop%0d", i));
        end
        check_flags("after random");
        for (int c = 0; c < CH; c++) begin
            while (mq[c].size() > 0) pop_model(c, $sformatf("drain ch%0d", c));
            pop_model(c, $sformatf("drain empty ch%0d", c));
        end

`ifdef TB_UART_PARITY_EN
        check("parity_err ch0 before", 32'(parity_err[0]), 32'(0));
        xfer(0, 8'h03, 1'b1, 1'b1);
        check("parity bad parity_err", 32'(parity_err[0]), 32'(1));
        check("parity bad discarded", 32'(fifo_empty[0]), 32'(1));
        xfer(0, 8'h03, 1'b1, 1'b0);
        pop_model(0, "parity good pop");
        check_flags("after parity");
`endif

        // Reset in the middle of a frame discards the partial byte and clears every sticky flag.
        rxd[0] = 1'b0;
        repeat (DIV) @(posedge clk);
        #1;
        rxd[0] = 1'b1;
        repeat (2 * DIV) @(posedge clk);
        #1;
        rxd[0] = 1'b0;
        repeat (DIV / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        rxd = '1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_flags("mid-frame reset");
        repeat (12 * DIV) @(posedge clk);
        #1;
        check("no byte after mid-frame reset", 32'(fifo_empty), 32'(2'b11));
        xfer(0, 8'h5A, 1'b1, 1'b0);
        pop_model(0, "post-reset pop");
        check_flags("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
